// File: rtl/uart_rx_monitor_if.sv
// ---------------------------------------------------------------------------
// uart_rx_monitor_if
//   Bundles the serial line, the FIFO read side and the status flags of the
//   UART receive monitor.
//
//   rxd         serial input, idle high, asynchronous to the clock
//   rd_en       pop request for the FIFO head
//   clr_err     synchronous clear of the sticky flags
//   rd_data     FIFO head byte, valid while empty=0
//   empty/full  FIFO occupancy flags
//   count       number of stored bytes
//   frame_err   one-cycle pulse per framing error
//   overrun     sticky: good byte dropped because the FIFO was full
//   false_start sticky: start bit rejected at its mid-point
//
//   master: the side that drives the line and reads the FIFO
//   slave : the receiver itself
// ---------------------------------------------------------------------------
interface uart_rx_monitor_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             rxd;
    logic             rd_en;
    logic             clr_err;
    logic [7:0]       rd_data;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    logic             frame_err;
    logic             overrun;
    logic             false_start;

    modport master (
        output rxd, rd_en, clr_err,
        input  rd_data, empty, full, count, frame_err, overrun, false_start
    );

    modport slave (
        input  rxd, rd_en, clr_err,
        output rd_data, empty, full, count, frame_err, overrun, false_start
    );
endinterface

// File: rtl/uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// uart_rx_monitor
//   8N1 UART receiver that decodes the serial stream and stores received
//   bytes in a first-word-fall-through FIFO. Flags false starts, framing
//   errors and FIFO overrun.
//
//   CLOCK_50  system clock, all logic on its rising edge
//   reset_n   asynchronous, active-low reset
//   bus       uart_rx_monitor_if.slave (line input, FIFO read side, flags)
//
//   CLKS_PER_BIT must be at least 8; FIFO_DEPTH must be a power of two, >= 2.
// ---------------------------------------------------------------------------
module uart_rx_monitor #(
    parameter int CLK_FREQ_HZ  = 50000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    uart_rx_monitor_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(CLKS_PER_BIT);

    localparam logic [TMR_W-1:0] HALF_T = TMR_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TMR_W-1:0] LAST_T = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] timer, timer_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic             push, fe_set, fs_set;

    // Line synchronizer: rx_p1 is the synchronized line, rx_p2 its previous
    // value for edge detection.
    logic rx_p0, rx_p1, rx_p2;
    // The sync flops come out of reset at 1, so their first samples are not
    // real line values. vld_pN tracks which stages hold genuine samples; a
    // line already low at reset release is then not mistaken for a start edge.
    logic vld_p0, vld_p1, vld_p2;
    logic rxs, fall;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             empty_i, full_i, pop_ok, push_ok;

    logic frame_err_q, overrun_q, false_start_q;

    assign rxs  = rx_p1;
    assign fall = vld_p2 & rx_p2 & ~rxs;

    // ---- stage: synchronizer ----
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            rx_p0  <= 1'b1;
            rx_p1  <= 1'b1;
            rx_p2  <= 1'b1;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            rx_p0  <= bus.rxd;
            rx_p1  <= rx_p0;
            rx_p2  <= rx_p1;
            vld_p0 <= 1'b1;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ---- stage: frame FSM ----
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            timer   <= timer_nxt;
            bit_idx <= bit_nxt;
        end
    end

    // Shift register is pure data; its contents only matter once 8 bits
    // have been sampled, so it carries no reset.
    always_ff @(posedge CLOCK_50) begin
        shreg <= shreg_nxt;
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        bit_nxt   = bit_idx;
        shreg_nxt = shreg;
        push      = 1'b0;
        fe_set    = 1'b0;
        fs_set    = 1'b0;
        unique case (state)
            IDLE: begin
                timer_nxt = '0;
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // Mid-point of the start bit: a line already back high was
                // a glitch, not a frame.
                if (timer == HALF_T) begin
                    timer_nxt = '0;
                    if (!rxs) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end else begin
                        fs_set    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (timer == LAST_T) begin
                    timer_nxt = '0;
                    shreg_nxt = {rxs, shreg[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (timer == LAST_T) begin
                    timer_nxt = '0;
                    if (rxs) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fe_set    = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Held-low line: wait for idle so one break gives one error.
                timer_nxt = '0;
                if (rxs) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                timer_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage: FIFO ----
    assign empty_i = (cnt == '0);
    assign full_i  = (cnt == FULL_C);
    assign pop_ok  = bus.rd_en & ~empty_i;
    // Fullness is judged before this cycle's pop; a coincident pop frees the
    // slot the push lands in.
    assign push_ok = push & (~full_i | pop_ok);

    always_ff @(posedge CLOCK_50) begin
        if (push_ok) begin
            mem[wr_ptr] <= shreg;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // ---- stage: status flags ----
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q   <= 1'b0;
            overrun_q     <= 1'b0;
            false_start_q <= 1'b0;
        end else begin
            frame_err_q <= fe_set;
            // A set in the same cycle as clr_err wins.
            if (push & ~push_ok) begin
                overrun_q <= 1'b1;
            end else if (bus.clr_err) begin
                overrun_q <= 1'b0;
            end
            if (fs_set) begin
                false_start_q <= 1'b1;
            end else if (bus.clr_err) begin
                false_start_q <= 1'b0;
            end
        end
    end

    // Head is masked while empty so the output reads 0 out of reset even
    // though the storage itself is never reset.
    assign bus.rd_data     = empty_i ? 8'h00 : mem[rd_ptr];
    assign bus.empty       = empty_i;
    assign bus.full        = full_i;
    assign bus.count       = cnt;
    assign bus.frame_err   = frame_err_q;
    assign bus.overrun     = overrun_q;
    assign bus.false_start = false_start_q;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_monitor
//   Drives 8N1 frames into uart_rx_monitor and checks the FIFO contents and
//   flags against a byte-queue model of the receiver.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_monitor;

    localparam int CLK_HZ  = 4000000;
    localparam int BAUD    = 100000;
    localparam int CPB     = CLK_HZ / BAUD;
    localparam int DEPTH   = 16;
    localparam int NOMINAL = CPB / 2 + 9 * CPB;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    uart_rx_monitor_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_rx_monitor #(
        .CLK_FREQ_HZ (CLK_HZ),
        .BAUD        (BAUD),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: queue of stored bytes, sticky overrun, error count.
    logic [7:0] model_q[$];
    logic       model_ovr = 1'b0;
    int         exp_fe = 0;
    logic [7:0] model_popped = 8'h00;
    int         lat_seen = -1;

    int fe_pulses = 0;
    always @(posedge clk) begin
        if (bus.frame_err === 1'b1) fe_pulses <= fe_pulses + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop(output logic [7:0] b);
        b = bus.rd_data;
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        bus.clr_err = 1'b1;
        tick(1);
        bus.clr_err = 1'b0;
    endtask

    // Sends one frame; stop selects the stop-bit level. pop_c >= 0 asserts
    // rd_en for the cycle with that index within the frame. The line is left
    // at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int pop_c,
                              output logic [7:0] popped);
        logic [9:0] bits;
        bit was_empty, full_before, did_pop;
        int meas;
        bits = {stop, b, 1'b0};
        was_empty   = (model_q.size() == 0);
        full_before = (model_q.size() == DEPTH);
        did_pop = 0;
        meas = -1;
        popped = 8'h00;
        for (int c = 0; c < 10 * CPB; c++) begin
            bus.rxd = bits[c / CPB];
            if (c == pop_c) begin
                popped = bus.rd_data;
                bus.rd_en = 1'b1;
                did_pop = 1;
            end
            tick(1);
            bus.rd_en = 1'b0;
            if (was_empty && meas < 0 && bus.empty === 1'b0) meas = c + 1;
        end
        if (was_empty && stop) lat_seen = meas;
        if (did_pop && model_q.size() > 0) model_popped = model_q.pop_front();
        if (stop) begin
            if (!full_before || did_pop) model_q.push_back(b);
            else model_ovr = 1'b1;
        end else begin
            exp_fe++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        bus.rxd = 1'b1;
        bus.rd_en = 1'b0;
        bus.clr_err = 1'b0;
        tick(5);
        reset_n = 1'b1;
        tick(1000);
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", bus.empty); end
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        n_tests++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", bus.full); end
        n_tests++; if ({bus.frame_err, bus.overrun, bus.false_start} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.frame_err, bus.overrun, bus.false_start});
        end
        n_tests++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", bus.rd_data); end
    endtask

    task automatic test_two_bytes;
        logic [7:0] d, e;
        send_frame(8'h55, 1'b1, -1, d);
        n_tests++; if (lat_seen < NOMINAL - 3 || lat_seen > NOMINAL + 3) begin
            n_fail++; $display("FAIL latency: got %0d cycles expected %0d +-3", lat_seen, NOMINAL);
        end
        send_frame(8'hA3, 1'b1, -1, d);
        tick(CPB);
        n_tests++; if (bus.count !== 5'(model_q.size())) begin n_fail++; $display("FAIL two_count: got %0d expected %0d", bus.count, model_q.size()); end
        repeat (2) begin
            e = model_q.pop_front();
            pop(d);
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL two_data: got %h expected %h", d, e); end
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL two_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_false_start;
        bus.rxd = 1'b0;
        tick(CPB / 4);
        bus.rxd = 1'b1;
        tick(CPB);
        n_tests++; if (bus.false_start !== 1'b1) begin n_fail++; $display("FAIL false_start_set: got %b expected 1", bus.false_start); end
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL false_start_count: got %0d expected 0", bus.count); end
        pulse_clr();
        n_tests++; if (bus.false_start !== 1'b0) begin n_fail++; $display("FAIL false_start_clr: got %b expected 0", bus.false_start); end
    endtask

    task automatic test_break;
        logic [7:0] d, e;
        int fe0;
        fe0 = fe_pulses;
        send_frame(8'h3C, 1'b0, -1, d);
        tick(2000);
        bus.rxd = 1'b1;
        tick(CPB);
        n_tests++; if (fe_pulses - fe0 !== 1) begin n_fail++; $display("FAIL break_fe_pulses: got %0d expected 1", fe_pulses - fe0); end
        n_tests++; if (bus.count !== '0) begin n_fail++; $display("FAIL break_count: got %0d expected 0", bus.count); end
        send_frame(8'h7E, 1'b1, -1, d);
        tick(CPB);
        e = model_q.pop_front();
        pop(d);
        n_tests++; if (d !== e) begin n_fail++; $display("FAIL break_next: got %h expected %h", d, e); end
    endtask

    task automatic test_overrun;
        logic [7:0] d, e;
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, -1, d);
        tick(CPB);
        n_tests++; if (bus.count !== 5'(model_q.size())) begin n_fail++; $display("FAIL ovr_count: got %0d expected %0d", bus.count, model_q.size()); end
        n_tests++; if (bus.full !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b expected 1", bus.full); end
        n_tests++; if (bus.overrun !== model_ovr) begin n_fail++; $display("FAIL ovr_flag: got %b expected %b", bus.overrun, model_ovr); end
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            pop(d);
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", d, e); end
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL ovr_empty: got %b expected 1", bus.empty); end
        pulse_clr();
        model_ovr = 1'b0;
        n_tests++; if (bus.overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b expected 0", bus.overrun); end
    endtask

    task automatic test_pop_at_push;
        logic [7:0] d, e;
        int pc;
        pc = (lat_seen > 0) ? lat_seen - 1 : NOMINAL + 2;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, -1, d);
        send_frame(8'h10, 1'b1, pc, d);
        tick(CPB);
        n_tests++; if (d !== model_popped) begin n_fail++; $display("FAIL pp_popped: got %h expected %h", d, model_popped); end
        n_tests++; if (bus.overrun !== model_ovr) begin n_fail++; $display("FAIL pp_overrun: got %b expected %b", bus.overrun, model_ovr); end
        n_tests++; if (bus.count !== 5'(model_q.size())) begin n_fail++; $display("FAIL pp_count: got %0d expected %0d", bus.count, model_q.size()); end
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            pop(d);
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL pp_data: got %h expected %h", d, e); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] d;
        logic [7:0] ab;
        send_frame(8'hC5, 1'b1, -1, d);
        tick(CPB);
        ab = 8'h0F;
        bus.rxd = 1'b0;
        tick(CPB);
        for (int i = 0; i < 4; i++) begin
            bus.rxd = ab[i];
            tick(CPB);
        end
        bus.rxd = ab[4];
        tick(CPB / 2);
        reset_n = 1'b0;
        tick(3);
        n_tests++; if (bus.count !== '0 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_flush: got count %0d empty %b expected 0 1", bus.count, bus.empty);
        end
        model_q.delete();
        model_ovr = 1'b0;
        reset_n = 1'b1;
        tick(2 * CPB);
        bus.rxd = 1'b1;
        tick(2 * CPB);
        send_frame(8'h81, 1'b1, -1, d);
        tick(CPB);
        n_tests++; if (bus.count !== 5'd1) begin n_fail++; $display("FAIL rst_mid_count: got %0d expected 1", bus.count); end
        n_tests++; if (bus.false_start !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fs: got %b expected 0", bus.false_start); end
        pop(d);
        void'(model_q.pop_front());
        n_tests++; if (d !== 8'h81) begin n_fail++; $display("FAIL rst_mid_data: got %h expected 81", d); end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty: got %b expected 1", bus.empty); end
    endtask

    task automatic test_random;
        logic [7:0] d, e, b;
        logic good;
        int fe0, efe0;
        fe0 = fe_pulses;
        efe0 = exp_fe;
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            send_frame(b, good, -1, d);
            if (!good) begin
                tick($urandom_range(1, CPB));
                bus.rxd = 1'b1;
            end
            tick($urandom_range(8, CPB));
            if ($urandom_range(0, 1) == 1 && model_q.size() > 0) begin
                e = model_q.pop_front();
                pop(d);
                n_tests++; if (d !== e) begin n_fail++; $display("FAIL rnd_data: got %h expected %h", d, e); end
            end
        end
        n_tests++; if (fe_pulses - fe0 !== exp_fe - efe0) begin
            n_fail++; $display("FAIL rnd_fe: got %0d expected %0d", fe_pulses - fe0, exp_fe - efe0);
        end
        n_tests++; if (bus.count !== 5'(model_q.size())) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", bus.count, model_q.size()); end
        while (model_q.size() > 0) begin
            e = model_q.pop_front();
            pop(d);
            n_tests++; if (d !== e) begin n_fail++; $display("FAIL rnd_drain: got %h expected %h", d, e); end
        end
        n_tests++; if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL rnd_empty: got %b expected 1", bus.empty); end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_false_start();
        test_break();
        test_overrun();
        test_pop_at_push();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
